udp_tx_arbiter: RTL and testbench
=================================

Name: udp_tx_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one UDP transmit path among NUM_REQ application requesters.
- Each requester presents an 8-bit AXI-Stream payload plus its source and destination ports.
- The arbiter grants one whole packet at a time, muxes that packet and its port pair to the UDP TX header-insertion stage, and routes tready back.
- A stall watchdog keeps a hung requester from locking the shared path.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- TIMEOUT_CYCLES, 1024: consecutive idle cycles of the granted requester, mid-packet, before abort (≥2).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- req_tdata_in  input  8*NUM_REQ  payload byte, requester i at [8i+7:8i]
- req_tvalid_in  input  NUM_REQ  per-requester tvalid
- req_tlast_in  input  NUM_REQ  per-requester tlast
- req_tready_out  output  NUM_REQ  per-requester tready
- req_src_port_in  input  16*NUM_REQ  UDP source port per requester
- req_dest_port_in  input  16*NUM_REQ  UDP destination port per requester
- udp_tx_tdata_out  output  8  muxed payload byte
- udp_tx_tvalid_out  output  1  muxed tvalid
- udp_tx_tlast_out  output  1  muxed tlast
- udp_tx_tready_in  input  1  downstream ready
- src_port_out  output  16  latched source port of the current packet
- dest_port_out  output  16  latched destination port of the current packet
- grant_out  output  NUM_REQ  one-hot current grant; zero when idle
- timeout_out  output  1  one-cycle pulse when a packet is aborted

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values: state IDLE, grant_out=0, last_grant=NUM_REQ-1 (so requester 0 wins first), all tready=0, udp_tx_tvalid/tlast/tdata=0, ports=0, timeout_out=0, idle counter=0.
- IDLE:
  - If any req_tvalid_in is set, pick the first set bit searching upward from last_grant+1, with wrap.
  - Register grant_out, src_port_out and dest_port_out from the winner. Go to XFER.
  - No tready is asserted in IDLE, so there is one arbitration cycle of gap between packets.
- XFER (combinational passthrough, zero added latency):
  - udp_tx_tdata/tvalid/tlast come from the granted lane.
  - req_tready_out[g] = udp_tx_tready_in; all other lanes see tready=0.
  - A handshake with tlast=1 sets last_grant=g, clears grant_out and returns to IDLE.
  - Ports stay stable from grant until return to IDLE.
- Idle counter (XFER only):
  - Clears on any cycle with req_tvalid_in[g]=1; otherwise increments.
  - On reaching TIMEOUT_CYCLES-1, go to FLUSH.
- FLUSH:
  - Drive udp_tx_tvalid=1, tlast=1, tdata=0x00 so downstream sees a terminated packet. The granted lane sees tready=0.
  - On handshake, pulse timeout_out for one cycle and go to DROP.
- DROP:
  - req_tready_out[g]=1 and udp_tx_tvalid=0; beats from lane g are discarded.
  - Exit to IDLE on a tlast beat, or after another TIMEOUT_CYCLES idle cycles.
  - On exit, set last_grant=g and clear grant_out.
- Requesters that drop tvalid while not granted are legal; no state is kept for them.
- Downstream backpressure (tready=0) in XFER or FLUSH does not advance the idle counter if the lane's tvalid is 1.
- Single-beat packet (tvalid and tlast on the first beat): IDLE → XFER → IDLE, 2 cycles minimum per packet.
- reset_n asserted mid-packet: all outputs clear immediately. After release the arbiter starts in IDLE with requester 0 highest priority. No partial-packet recovery is attempted.

Optional Feature:
- Macro: UDP_TX_ARB_STATS_EN.
- When defined, the block adds output pkt_count_out [16*NUM_REQ-1:0]:
  - Per-requester 16-bit counters of completed packets (XFER tlast handshakes), wrapping at 0xFFFF.
  - Packets aborted by timeout are not counted.
  - Counters reset to 0 on reset_n.
- When undefined, the port and the counters are absent and behaviour is otherwise identical.

Test Plan:
- Requester 1 alone sends a 5-byte packet 0x11..0x15, dest 0x1389 → grant_out=0010 one cycle after tvalid; bytes appear unchanged; dest_port_out=0x1389; tlast on 0x15; back to IDLE.
- All 4 requesters continuously valid with 3-byte packets → grant order 0,1,2,3,0; one idle cycle between packets; no interleaving of bytes.
- udp_tx_tready_in toggles 1,0,1,0 during requester 2's 4-byte packet → each byte is held until accepted; req_tready_out[2] mirrors tready; other lanes stay 0.
- TIMEOUT_CYCLES=16; requester 0 sends 2 bytes then stalls → after 16 idle cycles a 0x00 tlast beat is emitted and timeout_out pulses once; requester 0's later 3 bytes + tlast are absorbed with no udp_tx_tvalid; requester 3 is granted next.
- reset_n pulled low mid-packet of requester 3 → all outputs are 0 immediately; after release with requesters 0 and 3 valid, requester 0 wins.
- With UDP_TX_ARB_STATS_EN: 3 packets from requester 1 and 1 timed-out packet from requester 2 → pkt_count_out lane1=3, lane2=0.

Source files
------------

// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter
//   Packet-granular round-robin arbiter that shares one UDP TX path among
//   NUM_REQ AXI-Stream requesters. A whole packet is granted at a time; the
//   granted lane's payload is passed through combinationally and its port
//   pair is latched for the duration of the packet. A stall watchdog aborts
//   a packet whose requester goes quiet mid-packet: a terminating 0x00/tlast
//   beat is sent downstream, then the rest of the hung packet is discarded.
//
//   Optional feature (macro UDP_TX_ARB_STATS_EN): adds pkt_count_out, one
//   16-bit wrapping count of completed packets per requester.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   req_tdata_in          payload bytes, requester i at [8i+7:8i]
//   req_tvalid_in/tlast   per-requester stream qualifiers
//   req_tready_out        per-requester ready (only the granted lane)
//   req_src/dest_port_in  per-requester UDP ports, requester i at [16i+15:16i]
//   udp_tx_*              muxed stream toward header insertion
//   src/dest_port_out     ports latched at grant time
//   grant_out             one-hot grant, zero when idle
//   timeout_out           one-cycle pulse after an aborted packet is flushed
//   pkt_count_out         (UDP_TX_ARB_STATS_EN only) completed-packet counts
//
// state | meaning
// IDLE  | no grant; arbitrate among valid requesters
// XFER  | granted lane passed through to downstream
// FLUSH | watchdog fired; emit one 0x00 tlast beat downstream
// DROP  | swallow the rest of the hung packet from the granted lane

module udp_tx_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [8*NUM_REQ-1:0]    req_tdata_in,
   input  logic [NUM_REQ-1:0]      req_tvalid_in,
   input  logic [NUM_REQ-1:0]      req_tlast_in,
   output logic [NUM_REQ-1:0]      req_tready_out,
   input  logic [16*NUM_REQ-1:0]   req_src_port_in,
   input  logic [16*NUM_REQ-1:0]   req_dest_port_in,
   output logic [7:0]              udp_tx_tdata_out,
   output logic                    udp_tx_tvalid_out,
   output logic                    udp_tx_tlast_out,
   input  logic                    udp_tx_tready_in,
   output logic [15:0]             src_port_out,
   output logic [15:0]             dest_port_out,
   output logic [NUM_REQ-1:0]      grant_out,
   output logic                    timeout_out
`ifdef UDP_TX_ARB_STATS_EN
   ,
   output logic [16*NUM_REQ-1:0]   pkt_count_out
`endif
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_XFER  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DROP  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]   gidx_q, gidx_d;
   logic [IDX_W-1:0]   last_q, last_d;
   logic [15:0]        src_q, src_d;
   logic [15:0]        dest_q, dest_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               timeout_q, timeout_d;

   logic               win_found;
   logic [IDX_W-1:0]   win_idx;
   logic               lane_tvalid;
   logic               lane_tlast;
   logic [7:0]         lane_tdata;

   assign lane_tvalid = req_tvalid_in[gidx_q];
   assign lane_tlast  = req_tlast_in[gidx_q];
   assign lane_tdata  = req_tdata_in[{gidx_q, 3'b000} +: 8];

   // Search upward from last_grant+1 with wrap; the last lane visited is
   // last_grant itself, so a lone requester can win back-to-back.
   always_comb begin
      int cand;
      logic [IDX_W-1:0] cand_idx;
      cand      = 0;
      cand_idx  = '0;
      win_found = 1'b0;
      win_idx   = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand     = (int'(last_q) + i) % NUM_REQ;
         cand_idx = IDX_W'(cand);
         if (!win_found && req_tvalid_in[cand_idx]) begin
            win_found = 1'b1;
            win_idx   = cand_idx;
         end
      end
   end

   // Stream mux: zero-latency passthrough in XFER, synthetic tail in FLUSH,
   // unconditional sink on the granted lane in DROP.
   always_comb begin
      udp_tx_tdata_out  = 8'h00;
      udp_tx_tvalid_out = 1'b0;
      udp_tx_tlast_out  = 1'b0;
      req_tready_out    = '0;
      case (state_q)
         ST_XFER: begin
            udp_tx_tdata_out  = lane_tdata;
            udp_tx_tvalid_out = lane_tvalid;
            udp_tx_tlast_out  = lane_tlast;
            req_tready_out    = grant_q & {NUM_REQ{udp_tx_tready_in}};
         end
         ST_FLUSH: begin
            udp_tx_tvalid_out = 1'b1;
            udp_tx_tlast_out  = 1'b1;
         end
         ST_DROP: begin
            req_tready_out = grant_q;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      gidx_d    = gidx_q;
      last_d    = last_q;
      src_d     = src_q;
      dest_d    = dest_q;
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               grant_d          = '0;
               grant_d[win_idx] = 1'b1;
               gidx_d           = win_idx;
               src_d            = req_src_port_in[{win_idx, 4'b0000} +: 16];
               dest_d           = req_dest_port_in[{win_idx, 4'b0000} +: 16];
               cnt_d            = '0;
               state_d          = ST_XFER;
            end
         end
         ST_XFER: begin
            if (lane_tvalid) begin
               cnt_d = '0;
               if (udp_tx_tready_in && lane_tlast) begin
                  state_d = ST_IDLE;
                  last_d  = gidx_q;
                  grant_d = '0;
               end
            end else if (cnt_q == CNT_TC) begin
               cnt_d   = '0;
               state_d = ST_FLUSH;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_FLUSH: begin
            if (udp_tx_tready_in) begin
               timeout_d = 1'b1;
               cnt_d     = '0;
               state_d   = ST_DROP;
            end
         end
         ST_DROP: begin
            if (lane_tvalid) begin
               cnt_d = '0;
               if (lane_tlast) begin
                  state_d = ST_IDLE;
                  last_d  = gidx_q;
                  grant_d = '0;
               end
            end else if (cnt_q == CNT_TC) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
               last_d  = gidx_q;
               grant_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         grant_q   <= '0;
         gidx_q    <= '0;
         last_q    <= IDX_W'(NUM_REQ - 1);
         src_q     <= '0;
         dest_q    <= '0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         gidx_q    <= gidx_d;
         last_q    <= last_d;
         src_q     <= src_d;
         dest_q    <= dest_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign grant_out     = grant_q;
   assign src_port_out  = src_q;
   assign dest_port_out = dest_q;
   assign timeout_out   = timeout_q;

`ifdef UDP_TX_ARB_STATS_EN
   // Only clean XFER completions count; aborted packets end in DROP.
   logic        pkt_done;
   logic [15:0] pkt_cnt_q [NUM_REQ];
   logic [15:0] pkt_cnt_d [NUM_REQ];

   assign pkt_done = (state_q == ST_XFER) && lane_tvalid && lane_tlast && udp_tx_tready_in;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         pkt_cnt_d[i] = pkt_cnt_q[i];
         if (pkt_done && (gidx_q == IDX_W'(i))) begin
            pkt_cnt_d[i] = pkt_cnt_q[i] + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            pkt_cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            pkt_cnt_q[i] <= pkt_cnt_d[i];
         end
      end
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
      assign pkt_count_out[16*g +: 16] = pkt_cnt_q[g];
   end
`endif

endmodule

// File: tb/tb_udp_tx_arbiter.sv
module tb_udp_tx_arbiter;

   localparam int N  = 4;
   localparam int TO = 16;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [8*N-1:0]    req_tdata_in;
   logic [N-1:0]      req_tvalid_in;
   logic [N-1:0]      req_tlast_in;
   logic [N-1:0]      req_tready_out;
   logic [16*N-1:0]   req_src_port_in;
   logic [16*N-1:0]   req_dest_port_in;
   logic [7:0]        udp_tx_tdata_out;
   logic              udp_tx_tvalid_out;
   logic              udp_tx_tlast_out;
   logic              udp_tx_tready_in;
   logic [15:0]       src_port_out;
   logic [15:0]       dest_port_out;
   logic [N-1:0]      grant_out;
   logic              timeout_out;
`ifdef UDP_TX_ARB_STATS_EN
   logic [16*N-1:0]   pkt_count_out;
`endif

   int checks   = 0;
   int failures = 0;

   // per-lane source state: packets left, byte position, packet length, first byte
   int          pk_left [N];
   int          pos     [N];
   int          len     [N];
   logic [7:0]  base    [N];
   logic        stall   [N];
   logic [15:0] sp      [N];
   logic [15:0] dp      [N];

   always #5 clk = ~clk;

   udp_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .req_tdata_in      (req_tdata_in),
      .req_tvalid_in     (req_tvalid_in),
      .req_tlast_in      (req_tlast_in),
      .req_tready_out    (req_tready_out),
      .req_src_port_in   (req_src_port_in),
      .req_dest_port_in  (req_dest_port_in),
      .udp_tx_tdata_out  (udp_tx_tdata_out),
      .udp_tx_tvalid_out (udp_tx_tvalid_out),
      .udp_tx_tlast_out  (udp_tx_tlast_out),
      .udp_tx_tready_in  (udp_tx_tready_in),
      .src_port_out      (src_port_out),
      .dest_port_out     (dest_port_out),
      .grant_out         (grant_out),
      .timeout_out       (timeout_out)
`ifdef UDP_TX_ARB_STATS_EN
      ,
      .pkt_count_out     (pkt_count_out)
`endif
   );

   task automatic clear_model();
      for (int i = 0; i < N; i++) begin
         pk_left[i] = 0;
         pos[i]     = 0;
         len[i]     = 1;
         base[i]    = 8'h00;
         stall[i]   = 1'b0;
         sp[i]      = 16'h0000;
         dp[i]      = 16'h0000;
      end
   endtask

   task automatic apply_lanes();
      logic v;
      for (int i = 0; i < N; i++) begin
         v = (pk_left[i] > 0) && !stall[i];
         req_tvalid_in[i]             = v;
         req_tdata_in[8*i +: 8]       = v ? (base[i] + 8'(pos[i])) : 8'h00;
         req_tlast_in[i]              = v && (pos[i] == len[i] - 1);
         req_src_port_in[16*i +: 16]  = sp[i];
         req_dest_port_in[16*i +: 16] = dp[i];
      end
   endtask

   // inputs change on the falling edge; outputs sampled 1 ns later
   task automatic drive(input logic rdy);
      @(negedge clk);
      udp_tx_tready_in = rdy;
      apply_lanes();
      #1;
   endtask

   // advance each source on the handshake that the coming rising edge takes
   task automatic commit();
      for (int i = 0; i < N; i++) begin
         if (req_tvalid_in[i] && req_tready_out[i]) begin
            if (pos[i] == len[i] - 1) begin
               pos[i] = 0;
               pk_left[i]--;
            end else begin
               pos[i]++;
            end
         end
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      udp_tx_tready_in = 1'b0;
      clear_model();
      apply_lanes();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      clear_model();
      for (int i = 0; i < N; i++) begin
         pk_left[i] = 1; len[i] = 2; base[i] = 8'hE0; sp[i] = 16'hAAAA; dp[i] = 16'h5555;
      end
      drive(1'b1);
      drive(1'b1);
      checks++; if (grant_out !== 4'b0000) begin failures++; $display("FAIL reset_grant: got %b expected 0000", grant_out); end
      checks++; if (req_tready_out !== 4'b0000) begin failures++; $display("FAIL reset_tready: got %b expected 0000", req_tready_out); end
      checks++; if (udp_tx_tvalid_out !== 1'b0) begin failures++; $display("FAIL reset_tvalid: got %b expected 0", udp_tx_tvalid_out); end
      checks++; if (udp_tx_tlast_out !== 1'b0) begin failures++; $display("FAIL reset_tlast: got %b expected 0", udp_tx_tlast_out); end
      checks++; if (udp_tx_tdata_out !== 8'h00) begin failures++; $display("FAIL reset_tdata: got %h expected 00", udp_tx_tdata_out); end
      checks++; if (src_port_out !== 16'h0000) begin failures++; $display("FAIL reset_src: got %h expected 0000", src_port_out); end
      checks++; if (dest_port_out !== 16'h0000) begin failures++; $display("FAIL reset_dest: got %h expected 0000", dest_port_out); end
      checks++; if (timeout_out !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %b expected 0", timeout_out); end
`ifdef UDP_TX_ARB_STATS_EN
      checks++; if (pkt_count_out !== 64'h0) begin failures++; $display("FAIL reset_pkt_count: got %h expected 0", pkt_count_out); end
`endif
   endtask

   task automatic test_single_packet();
      do_reset();
      pk_left[1] = 1; len[1] = 5; base[1] = 8'h11; sp[1] = 16'h0400; dp[1] = 16'h1389;
      drive(1'b1);
      checks++; if (grant_out !== 4'b0000 || udp_tx_tvalid_out !== 1'b0) begin failures++; $display("FAIL single_arb_cycle: got grant=%b tvalid=%b expected 0000/0", grant_out, udp_tx_tvalid_out); end
      commit();
      for (int k = 0; k < 5; k++) begin
         drive(1'b1);
         checks++; if (grant_out !== 4'b0010) begin failures++; $display("FAIL single_grant[%0d]: got %b expected 0010", k, grant_out); end
         checks++; if (udp_tx_tdata_out !== 8'h11 + 8'(k) || udp_tx_tvalid_out !== 1'b1) begin failures++; $display("FAIL single_data[%0d]: got %h/%b expected %h/1", k, udp_tx_tdata_out, udp_tx_tvalid_out, 8'h11 + 8'(k)); end
         checks++; if (udp_tx_tlast_out !== (k == 4)) begin failures++; $display("FAIL single_tlast[%0d]: got %b expected %b", k, udp_tx_tlast_out, (k == 4)); end
         checks++; if (req_tready_out !== 4'b0010) begin failures++; $display("FAIL single_tready[%0d]: got %b expected 0010", k, req_tready_out); end
         checks++; if (dest_port_out !== 16'h1389 || src_port_out !== 16'h0400) begin failures++; $display("FAIL single_ports[%0d]: got %h/%h expected 0400/1389", k, src_port_out, dest_port_out); end
         commit();
      end
      drive(1'b1);
      checks++; if (grant_out !== 4'b0000 || udp_tx_tvalid_out !== 1'b0 || req_tready_out !== 4'b0000) begin failures++; $display("FAIL single_back_idle: got grant=%b tvalid=%b tready=%b expected 0000/0/0000", grant_out, udp_tx_tvalid_out, req_tready_out); end
   endtask

   task automatic test_round_robin();
      int order [5] = '{0, 1, 2, 3, 0};
      int g;
      logic [3:0] exp_g;
      do_reset();
      for (int i = 0; i < N; i++) begin
         pk_left[i] = 1; len[i] = 3; base[i] = 8'(8'h40 + 16 * i);
      end
      pk_left[0] = 2;
      for (int p = 0; p < 5; p++) begin
         g = order[p];
         exp_g = 4'(1 << g);
         drive(1'b1);
         checks++; if (grant_out !== 4'b0000 || udp_tx_tvalid_out !== 1'b0) begin failures++; $display("FAIL rr_gap[%0d]: got grant=%b tvalid=%b expected 0000/0", p, grant_out, udp_tx_tvalid_out); end
         commit();
         for (int b = 0; b < 3; b++) begin
            drive(1'b1);
            checks++; if (grant_out !== exp_g || req_tready_out !== exp_g) begin failures++; $display("FAIL rr_grant[%0d.%0d]: got grant=%b tready=%b expected %b", p, b, grant_out, req_tready_out, exp_g); end
            checks++; if (udp_tx_tdata_out !== 8'(8'h40 + 16 * g + b) || udp_tx_tlast_out !== (b == 2)) begin failures++; $display("FAIL rr_data[%0d.%0d]: got %h/%b expected %h/%b", p, b, udp_tx_tdata_out, udp_tx_tlast_out, 8'(8'h40 + 16 * g + b), (b == 2)); end
            commit();
         end
      end
      drive(1'b1);
      checks++; if (grant_out !== 4'b0000) begin failures++; $display("FAIL rr_done: got %b expected 0000", grant_out); end
   endtask

   task automatic test_backpressure();
      logic rdy;
      int   byte_i;
      do_reset();
      pk_left[2] = 1; len[2] = 4; base[2] = 8'h60;
      pk_left[3] = 1; len[3] = 2; base[3] = 8'h70;
      drive(1'b1);
      commit();
      for (int k = 0; k < 7; k++) begin
         rdy    = (k % 2 == 0);
         byte_i = (k + 1) / 2;
         drive(rdy);
         checks++; if (grant_out !== 4'b0100) begin failures++; $display("FAIL bp_grant[%0d]: got %b expected 0100", k, grant_out); end
         checks++; if (udp_tx_tdata_out !== 8'(8'h60 + byte_i) || udp_tx_tvalid_out !== 1'b1 || udp_tx_tlast_out !== (byte_i == 3)) begin failures++; $display("FAIL bp_data[%0d]: got %h/%b/%b expected %h/1/%b", k, udp_tx_tdata_out, udp_tx_tvalid_out, udp_tx_tlast_out, 8'(8'h60 + byte_i), (byte_i == 3)); end
         checks++; if (req_tready_out !== (rdy ? 4'b0100 : 4'b0000)) begin failures++; $display("FAIL bp_tready[%0d]: got %b expected %b", k, req_tready_out, (rdy ? 4'b0100 : 4'b0000)); end
         commit();
      end
      drive(1'b1);
      checks++; if (grant_out !== 4'b0000) begin failures++; $display("FAIL bp_gap: got %b expected 0000", grant_out); end
      commit();
      drive(1'b1);
      checks++; if (grant_out !== 4'b1000 || udp_tx_tdata_out !== 8'h70) begin failures++; $display("FAIL bp_next: got %b/%h expected 1000/70", grant_out, udp_tx_tdata_out); end
      commit();
   endtask

   task automatic test_timeout();
      int pulses = 0;
      do_reset();
      pk_left[0] = 1; len[0] = 5; base[0] = 8'h80;
      pk_left[3] = 1; len[3] = 3; base[3] = 8'h90;
      drive(1'b1);
      commit();
      for (int k = 0; k < 2; k++) begin
         drive(1'b1);
         checks++; if (grant_out !== 4'b0001 || udp_tx_tdata_out !== 8'(8'h80 + k)) begin failures++; $display("FAIL to_pre[%0d]: got %b/%h expected 0001/%h", k, grant_out, udp_tx_tdata_out, 8'(8'h80 + k)); end
         commit();
      end
      stall[0] = 1'b1;
      for (int j = 0; j < TO; j++) begin
         drive(1'b1);
         if (timeout_out) pulses++;
         checks++; if ({grant_out, udp_tx_tvalid_out} !== {4'b0001, 1'b0}) begin failures++; $display("FAIL to_wait[%0d]: got grant=%b tvalid=%b expected 0001/0", j, grant_out, udp_tx_tvalid_out); end
         commit();
      end
      // flush beat held under backpressure, then accepted
      for (int f = 0; f < 2; f++) begin
         drive(f == 1);
         if (timeout_out) pulses++;
         checks++; if ({udp_tx_tvalid_out, udp_tx_tlast_out, udp_tx_tdata_out, req_tready_out, timeout_out} !== {1'b1, 1'b1, 8'h00, 4'b0000, 1'b0}) begin failures++; $display("FAIL to_flush[%0d]: got v=%b l=%b d=%h r=%b t=%b expected 1/1/00/0000/0", f, udp_tx_tvalid_out, udp_tx_tlast_out, udp_tx_tdata_out, req_tready_out, timeout_out); end
         commit();
      end
      stall[0] = 1'b0;
      for (int d = 0; d < 3; d++) begin
         drive(1'b1);
         if (timeout_out) pulses++;
         checks++; if (timeout_out !== (d == 0)) begin failures++; $display("FAIL to_pulse[%0d]: got %b expected %b", d, timeout_out, (d == 0)); end
         checks++; if (udp_tx_tvalid_out !== 1'b0 || req_tready_out !== 4'b0001 || grant_out !== 4'b0001) begin failures++; $display("FAIL to_drop[%0d]: got v=%b r=%b g=%b expected 0/0001/0001", d, udp_tx_tvalid_out, req_tready_out, grant_out); end
         commit();
      end
      drive(1'b1);
      if (timeout_out) pulses++;
      checks++; if (grant_out !== 4'b0000 || udp_tx_tvalid_out !== 1'b0) begin failures++; $display("FAIL to_gap: got %b/%b expected 0000/0", grant_out, udp_tx_tvalid_out); end
      commit();
      drive(1'b1);
      if (timeout_out) pulses++;
      checks++; if (grant_out !== 4'b1000 || udp_tx_tdata_out !== 8'h90) begin failures++; $display("FAIL to_next: got %b/%h expected 1000/90", grant_out, udp_tx_tdata_out); end
      commit();
      checks++; if (pulses !== 1) begin failures++; $display("FAIL to_pulse_count: got %0d expected 1", pulses); end
   endtask

   task automatic test_reset_mid_packet();
      do_reset();
      pk_left[3] = 1; len[3] = 4; base[3] = 8'hA0; sp[3] = 16'h1234; dp[3] = 16'h5678;
      drive(1'b1);
      commit();
      drive(1'b1);
      checks++; if (grant_out !== 4'b1000 || udp_tx_tdata_out !== 8'hA0 || dest_port_out !== 16'h5678) begin failures++; $display("FAIL rm_pre: got %b/%h/%h expected 1000/a0/5678", grant_out, udp_tx_tdata_out, dest_port_out); end
      commit();
      drive(1'b1);
      #1 reset_n = 1'b0;
      #1;
      checks++; if ({grant_out, req_tready_out, udp_tx_tvalid_out, udp_tx_tlast_out, udp_tx_tdata_out} !== 18'h0) begin failures++; $display("FAIL rm_async_stream: got g=%b r=%b v=%b l=%b d=%h expected all 0", grant_out, req_tready_out, udp_tx_tvalid_out, udp_tx_tlast_out, udp_tx_tdata_out); end
      checks++; if ({src_port_out, dest_port_out, timeout_out} !== 33'h0) begin failures++; $display("FAIL rm_async_ports: got %h/%h/%b expected 0000/0000/0", src_port_out, dest_port_out, timeout_out); end
      pk_left[0] = 1; len[0] = 2; base[0] = 8'hB0; dp[0] = 16'h0BB0;
      apply_lanes();
      @(negedge clk);
      reset_n = 1'b1;
      drive(1'b1);
      checks++; if (grant_out !== 4'b0001 || dest_port_out !== 16'h0BB0) begin failures++; $display("FAIL rm_after: got %b/%h expected 0001/0bb0", grant_out, dest_port_out); end
      commit();
   endtask

`ifdef UDP_TX_ARB_STATS_EN
   task automatic test_stats();
      int pulses = 0;
      do_reset();
      pk_left[1] = 3; len[1] = 2; base[1] = 8'hC0;
      pk_left[2] = 1; len[2] = 3; base[2] = 8'hD0;
      for (int c = 0; c < 150; c++) begin
         stall[2] = (pos[2] >= 1);
         drive(1'b1);
         if (timeout_out) pulses++;
         commit();
      end
      checks++; if (pkt_count_out[31:16] !== 16'd3) begin failures++; $display("FAIL stats_lane1: got %0d expected 3", pkt_count_out[31:16]); end
      checks++; if (pkt_count_out[47:32] !== 16'd0) begin failures++; $display("FAIL stats_lane2: got %0d expected 0", pkt_count_out[47:32]); end
      checks++; if (pkt_count_out[15:0] !== 16'd0 || pkt_count_out[63:48] !== 16'd0) begin failures++; $display("FAIL stats_others: got %h expected 0/0", {pkt_count_out[63:48], pkt_count_out[15:0]}); end
      checks++; if (pulses !== 1) begin failures++; $display("FAIL stats_timeouts: got %0d expected 1", pulses); end
      checks++; if (grant_out !== 4'b0000) begin failures++; $display("FAIL stats_idle: got %b expected 0000", grant_out); end
   endtask
`endif

   initial begin
      reset_n          = 1'b0;
      udp_tx_tready_in = 1'b0;
      req_tdata_in     = '0;
      req_tvalid_in    = '0;
      req_tlast_in     = '0;
      req_src_port_in  = '0;
      req_dest_port_in = '0;
      test_reset();
      test_single_packet();
      test_round_robin();
      test_backpressure();
      test_timeout();
      test_reset_mid_packet();
`ifdef UDP_TX_ARB_STATS_EN
      test_stats();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
